// File: rtl/vend_sequencer_pkg.sv
// Shared types and constants for the vending transaction controller.
package vend_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CREDIT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } vend_state_e;

  // Coin values in credit units (100 won each)
  localparam int unsigned COIN_100_U = 1;
  localparam int unsigned COIN_500_U = 5;
  localparam int unsigned COIN_VAL_W = 3;

endpackage

// File: rtl/vend_sequencer_timeout_ctr.sv
// Inactivity counter for auto-refund: counts enabled cycles, clears on request,
// flags expiry combinationally on the TIMEOUT_CYC-th consecutive enabled cycle.
module vend_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic clr,
  input  logic cnt_en,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expire_c = cnt_en && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_en && !expire_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction controller: coin credit, price check, dispenser and change handshakes.
// Optional auto-refund on inactivity when AUTO_REFUND_EN is defined.
module vend_sequencer
  import vend_sequencer_pkg::*;
#(
  parameter int unsigned               NPROD       = 4,
  parameter int unsigned               CREDIT_W    = 4,
  parameter logic [NPROD*CREDIT_W-1:0] PRICES      = (NPROD*CREDIT_W)'(16'h8654),
  parameter int unsigned               TIMEOUT_CYC = 1000
) (
  input  logic                       CLK,
  input  logic                       nRESET,
  input  logic                       coin_100,
  input  logic                       coin_500,
  input  logic [NPROD-1:0]           sel,
  input  logic                       cancel,
  input  logic                       disp_ack,
  input  logic                       chg_ack,
  output logic                       disp_req,
  output logic [$clog2(NPROD)-1:0]   disp_id,
  output logic                       chg_req,
  output logic [CREDIT_W-1:0]        credit,
  output logic                       reject,
  output logic                       coin_reject,
  output logic                       coin_block,
  output logic                       busy
);

  localparam int unsigned ID_W = $clog2(NPROD);

  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                disp_req_q, disp_req_d;
  logic [ID_W-1:0]     disp_id_q, disp_id_d;
  logic                chg_req_q, chg_req_d;
  logic                reject_q, reject_d;
  logic                coin_reject_q, coin_reject_d;
  logic                coin_block_q, coin_block_d;
  logic                busy_q, busy_d;

  logic                  coin_any_c;
  logic [COIN_VAL_W-1:0] coin_val_c;
  logic [CREDIT_W:0]     add_sum_c;
  logic                  add_ovf_c;
  logic [CREDIT_W-1:0]   price_c;
  logic [ID_W-1:0]       idx_c;
  logic                  sel_ok_c;
  logic                  to_expire_c;

  // Both coins in one cycle are summed and checked once
  assign coin_any_c = coin_100 | coin_500;
  assign coin_val_c = (coin_100 ? COIN_VAL_W'(COIN_100_U) : COIN_VAL_W'(0))
                    + (coin_500 ? COIN_VAL_W'(COIN_500_U) : COIN_VAL_W'(0));
  assign add_sum_c  = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val_c);
  assign add_ovf_c  = add_sum_c[CREDIT_W];

  // Price mux; only meaningful when sel is one-hot
  always_comb begin
    price_c = '0;
    idx_c   = '0;
    for (int unsigned i = 0; i < NPROD; i++) begin
      if (sel[i]) begin
        price_c = PRICES[i*CREDIT_W +: CREDIT_W];
        idx_c   = ID_W'(i);
      end
    end
  end

  assign sel_ok_c = $onehot(sel) && (credit_q >= price_c);

`ifdef AUTO_REFUND_EN
  logic idle_c;

  // Any activity, or any state other than CREDIT, holds the counter at zero
  assign idle_c = (state_q == ST_CREDIT) && !coin_any_c && !cancel && (sel == '0);

  vend_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .CLK      (CLK),
    .nRESET   (nRESET),
    .clr      (!idle_c),
    .cnt_en   (idle_c),
    .expire_c (to_expire_c)
  );
`else
  // No inactivity timer in this build; CREDIT is held indefinitely
  localparam int unsigned TIMEOUT_UNUSED = TIMEOUT_CYC;
  assign to_expire_c = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    disp_req_d    = disp_req_q;
    disp_id_d     = disp_id_q;
    chg_req_d     = chg_req_q;
    reject_d      = 1'b0;
    coin_reject_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (coin_any_c) begin
          if (add_ovf_c) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = add_sum_c[CREDIT_W-1:0];
            state_d  = ST_CREDIT;
          end
        end
      end

      // Coin beats cancel beats select; cancel beats a simultaneous select
      ST_CREDIT: begin
        if (coin_any_c) begin
          if (add_ovf_c) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = add_sum_c[CREDIT_W-1:0];
          end
        end else if (cancel) begin
          chg_req_d = 1'b1;
          state_d   = ST_CHANGE;
        end else if (sel != '0) begin
          if (sel_ok_c) begin
            credit_d   = credit_q - price_c;
            disp_id_d  = idx_c;
            disp_req_d = 1'b1;
            state_d    = ST_DISPENSE;
          end else begin
            reject_d = 1'b1;
          end
        end else if (to_expire_c) begin
          chg_req_d = 1'b1;
          state_d   = ST_CHANGE;
        end
      end

      ST_DISPENSE: begin
        coin_reject_d = coin_any_c;
        if (disp_ack) begin
          disp_req_d = 1'b0;
          disp_id_d  = '0;
          if (credit_q != '0) begin
            chg_req_d = 1'b1;
            state_d   = ST_CHANGE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_CHANGE: begin
        coin_reject_d = coin_any_c;
        if (credit_q == '0) begin
          chg_req_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (chg_ack) begin
          credit_d = credit_q - CREDIT_W'(1);
          if (credit_q == CREDIT_W'(1)) begin
            chg_req_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    coin_block_d = (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      disp_req_q    <= 1'b0;
      disp_id_q     <= '0;
      chg_req_q     <= 1'b0;
      reject_q      <= 1'b0;
      coin_reject_q <= 1'b0;
      coin_block_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      disp_req_q    <= disp_req_d;
      disp_id_q     <= disp_id_d;
      chg_req_q     <= chg_req_d;
      reject_q      <= reject_d;
      coin_reject_q <= coin_reject_d;
      coin_block_q  <= coin_block_d;
      busy_q        <= busy_d;
    end
  end

  assign disp_req    = disp_req_q;
  assign disp_id     = disp_id_q;
  assign chg_req     = chg_req_q;
  assign credit      = credit_q;
  assign reject      = reject_q;
  assign coin_reject = coin_reject_q;
  assign coin_block  = coin_block_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Scoreboard bench for vend_sequencer: expected outputs queued per stimulus cycle,
// compared one cycle later. Timeout behaviour follows AUTO_REFUND_EN.
module tb_vend_sequencer;

  logic       CLK = 1'b0;
  logic       nRESET = 1'b0;
  logic       coin_100 = 1'b0;
  logic       coin_500 = 1'b0;
  logic [3:0] sel = 4'd0;
  logic       cancel = 1'b0;
  logic       disp_ack = 1'b0;
  logic       chg_ack = 1'b0;
  logic       disp_req;
  logic [1:0] disp_id;
  logic       chg_req;
  logic [3:0] credit;
  logic       reject;
  logic       coin_reject;
  logic       coin_block;
  logic       busy;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic       dreq;
    logic [1:0] did;
    logic       creq;
    logic [3:0] cr;
    logic       rej;
    logic       crej;
    logic       blk;
    logic       bsy;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  vend_sequencer #(
    .NPROD       (4),
    .CREDIT_W    (4),
    .PRICES      (16'h8654),
    .TIMEOUT_CYC (16)
  ) dut (
    .CLK         (CLK),
    .nRESET      (nRESET),
    .coin_100    (coin_100),
    .coin_500    (coin_500),
    .sel         (sel),
    .cancel      (cancel),
    .disp_ack    (disp_ack),
    .chg_ack     (chg_ack),
    .disp_req    (disp_req),
    .disp_id     (disp_id),
    .chg_req     (chg_req),
    .credit      (credit),
    .reject      (reject),
    .coin_reject (coin_reject),
    .coin_block  (coin_block),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input string tag, input logic dreq, input logic [1:0] did,
                          input logic creq, input logic [3:0] cr, input logic rej,
                          input logic crej, input logic blk, input logic bsy);
    exp_t e;
    e.dreq = dreq; e.did = did; e.creq = creq; e.cr = cr;
    e.rej = rej; e.crej = crej; e.blk = blk; e.bsy = bsy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_cmp();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk({t, ".disp_req"},    disp_req,    e.dreq);
      if (e.dreq) chk({t, ".disp_id"}, disp_id, e.did);
      chk({t, ".chg_req"},     chg_req,     e.creq);
      chk({t, ".credit"},      credit,      e.cr);
      chk({t, ".reject"},      reject,      e.rej);
      chk({t, ".coin_reject"}, coin_reject, e.crej);
      chk({t, ".coin_block"},  coin_block,  e.blk);
      chk({t, ".busy"},        busy,        e.bsy);
    end
  endtask

  // Inputs already driven; expectation queued, then compared after the edge
  task automatic step(input string tag, input logic dreq, input logic [1:0] did,
                      input logic creq, input logic [3:0] cr, input logic rej,
                      input logic crej, input logic blk, input logic bsy);
    push_exp(tag, dreq, did, creq, cr, rej, crej, blk, bsy);
    @(posedge CLK);
    #1;
    coin_100 = 1'b0;
    coin_500 = 1'b0;
    sel      = 4'd0;
    cancel   = 1'b0;
    pop_cmp();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    push_exp("reset", 0, 0, 0, 4'd0, 0, 0, 0, 0);
    pop_cmp();
    @(posedge CLK);
    #1;
    nRESET = 1'b1;

    // IDLE ignores select and cancel
    sel = 4'b0001; cancel = 1'b1;
    step("idle_sel", 0, 0, 0, 4'd0, 0, 0, 0, 0);

    // Credit 6, buy P2 (6), no change
    coin_500 = 1'b1; step("t1_c500", 0, 0, 0, 4'd5, 0, 0, 0, 1);
    coin_100 = 1'b1; step("t1_c100", 0, 0, 0, 4'd6, 0, 0, 0, 1);
    sel = 4'b0100;   step("t1_sel2", 1, 2'd2, 0, 4'd0, 0, 0, 1, 1);
    coin_100 = 1'b1; step("t1_coin_disp", 1, 2'd2, 0, 4'd0, 0, 1, 1, 1);
    sel = 4'b0001;   step("t1_sel_disp", 1, 2'd2, 0, 4'd0, 0, 0, 1, 1);
    disp_ack = 1'b1; step("t1_ack", 0, 0, 0, 4'd0, 0, 0, 0, 0);
    disp_ack = 1'b0;

    // Credit 8 (coins summed), buy P0 (4), 4 coins change
    coin_500 = 1'b1; coin_100 = 1'b1; step("t2_both", 0, 0, 0, 4'd6, 0, 0, 0, 1);
    coin_100 = 1'b1; step("t2_c7", 0, 0, 0, 4'd7, 0, 0, 0, 1);
    coin_100 = 1'b1; step("t2_c8", 0, 0, 0, 4'd8, 0, 0, 0, 1);
    sel = 4'b0001;   step("t2_sel0", 1, 2'd0, 0, 4'd4, 0, 0, 1, 1);
    disp_ack = 1'b1; step("t2_ack", 0, 0, 1, 4'd4, 0, 0, 1, 1);
    disp_ack = 1'b0; chg_ack = 1'b1;
    step("t2_chg3", 0, 0, 1, 4'd3, 0, 0, 1, 1);
    step("t2_chg2", 0, 0, 1, 4'd2, 0, 0, 1, 1);
    step("t2_chg1", 0, 0, 1, 4'd1, 0, 0, 1, 1);
    step("t2_chg0", 0, 0, 0, 4'd0, 0, 0, 0, 0);
    step("t2_idle", 0, 0, 0, 4'd0, 0, 0, 0, 0);
    chg_ack = 1'b0;

    // Rejects: price above credit, multi-hot; then price equal to credit
    coin_100 = 1'b1; step("t3_c1", 0, 0, 0, 4'd1, 0, 0, 0, 1);
    coin_100 = 1'b1; step("t3_c2", 0, 0, 0, 4'd2, 0, 0, 0, 1);
    coin_100 = 1'b1; cancel = 1'b1; step("t3_coin_wins", 0, 0, 0, 4'd3, 0, 0, 0, 1);
    coin_100 = 1'b1; step("t3_c4", 0, 0, 0, 4'd4, 0, 0, 0, 1);
    sel = 4'b1000;   step("t3_rej_p3", 0, 0, 0, 4'd4, 1, 0, 0, 1);
    step("t3_rej_drop", 0, 0, 0, 4'd4, 0, 0, 0, 1);
    sel = 4'b0011;   step("t3_rej_multi", 0, 0, 0, 4'd4, 1, 0, 0, 1);
    sel = 4'b0001;   step("t3_exact", 1, 2'd0, 0, 4'd0, 0, 0, 1, 1);
    disp_ack = 1'b1; step("t3_ack", 0, 0, 0, 4'd0, 0, 0, 0, 0);
    disp_ack = 1'b0;

    // Overflow boundary at 15
    coin_500 = 1'b1; step("t4_c5", 0, 0, 0, 4'd5, 0, 0, 0, 1);
    coin_500 = 1'b1; step("t4_c10", 0, 0, 0, 4'd10, 0, 0, 0, 1);
    for (int i = 11; i <= 14; i++) begin
      coin_100 = 1'b1;
      step("t4_fill", 0, 0, 0, 4'(i), 0, 0, 0, 1);
    end
    coin_500 = 1'b1; step("t4_ovf500", 0, 0, 0, 4'd14, 0, 1, 0, 1);
    coin_100 = 1'b1; step("t4_c15", 0, 0, 0, 4'd15, 0, 0, 0, 1);
    coin_100 = 1'b1; step("t4_ovf100", 0, 0, 0, 4'd15, 0, 1, 0, 1);
    cancel = 1'b1;   step("t4_cancel", 0, 0, 1, 4'd15, 0, 0, 1, 1);
    coin_500 = 1'b1; step("t4_coin_chg", 0, 0, 1, 4'd15, 0, 1, 1, 1);
    chg_ack = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step("t4_drain", 0, 0, (i < 15), 4'(15 - i), 0, 0, (i < 15), (i < 15));
    end
    chg_ack = 1'b0;

    // Cancel with credit 5, ack held 5 cycles
    coin_500 = 1'b1; step("t5_c5", 0, 0, 0, 4'd5, 0, 0, 0, 1);
    cancel = 1'b1;   step("t5_cancel", 0, 0, 1, 4'd5, 0, 0, 1, 1);
    chg_ack = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step("t5_drain", 0, 0, (i < 5), 4'(5 - i), 0, 0, (i < 5), (i < 5));
    end
    chg_ack = 1'b0;

    // Asynchronous reset in the middle of CHANGE
    coin_500 = 1'b1; step("t5_r_c5", 0, 0, 0, 4'd5, 0, 0, 0, 1);
    cancel = 1'b1;   step("t5_r_cancel", 0, 0, 1, 4'd5, 0, 0, 1, 1);
    chg_ack = 1'b1;
    step("t5_r_chg4", 0, 0, 1, 4'd4, 0, 0, 1, 1);
    step("t5_r_chg3", 0, 0, 1, 4'd3, 0, 0, 1, 1);
    nRESET = 1'b0;
    chg_ack = 1'b0;
    #1;
    push_exp("t5_async_rst", 0, 0, 0, 4'd0, 0, 0, 0, 0);
    pop_cmp();
    @(posedge CLK);
    #1;
    nRESET = 1'b1;
    step("t5_post_rst", 0, 0, 0, 4'd0, 0, 0, 0, 0);

    // Inactivity: a select refusal restarts the count
    coin_100 = 1'b1; step("t6_c1", 0, 0, 0, 4'd1, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step("t6_wait_a", 0, 0, 0, 4'd1, 0, 0, 0, 1);
    sel = 4'b1000;   step("t6_rej", 0, 0, 0, 4'd1, 1, 0, 0, 1);
    for (int i = 0; i < 15; i++) step("t6_wait_b", 0, 0, 0, 4'd1, 0, 0, 0, 1);
`ifdef AUTO_REFUND_EN
    step("t6_timeout", 0, 0, 1, 4'd1, 0, 0, 1, 1);
    chg_ack = 1'b1;
    step("t6_refund", 0, 0, 0, 4'd0, 0, 0, 0, 0);
    chg_ack = 1'b0;
`else
    step("t6_no_timeout", 0, 0, 0, 4'd1, 0, 0, 0, 1);
    for (int i = 0; i < 30; i++) step("t6_hold", 0, 0, 0, 4'd1, 0, 0, 0, 1);
    cancel = 1'b1;   step("t6_cancel", 0, 0, 1, 4'd1, 0, 0, 1, 1);
    chg_ack = 1'b1;
    step("t6_refund", 0, 0, 0, 4'd0, 0, 0, 0, 0);
    chg_ack = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
